toy_wb_port_arbiter: RTL and testbench

Round-robin writeback scheduler that shares a small set of physical-regfile write ports among all execution units. Each cycle it selects up to PORT_NUM pending EU writebacks and presents the grants as a same-cycle forward notification. It then drives the registered write on the following cycle. It sits between the EU result buses and the physical regfile / status bitmap, feeding both the forward-status and write-status inputs.

---
 rtl/toy_wb_port_arbiter_pkg.sv | 13 +
 rtl/toy_wb_port_arbiter_if.sv | 38 +++
 rtl/toy_wb_rr_multi_sel.sv | 88 ++++++++
 rtl/toy_wb_port_arbiter.sv | 114 +++++++++++
 tb/tb_toy_wb_port_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/toy_wb_port_arbiter_pkg.sv
// Shared core constants and types for the writeback port arbiter.
package toy_wb_port_arbiter_pkg;

  localparam int EU_NUM           = 10;
  localparam int EU_NUM_WIDTH     = 4;
  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int REG_WIDTH        = 32;
  localparam int WB_PORT_NUM      = 4;

  typedef logic [EU_NUM_WIDTH-1:0]     eu_id_t;
  typedef logic [PHY_REG_ID_WIDTH-1:0] preg_id_t;

endpackage

// File: rtl/toy_wb_port_arbiter_if.sv
// Writeback bus between the execution units and the arbiter.
// The master side is the set of EUs; the slave side is the arbiter.
interface toy_wb_port_arbiter_if
  import toy_wb_port_arbiter_pkg::*;
#(
  parameter int REQ_NUM    = EU_NUM,
  parameter int PORT_NUM   = WB_PORT_NUM,
  parameter int DATA_WIDTH = REG_WIDTH
) ();

  logic [REQ_NUM-1:0]                           v_req_vld;
  logic [REQ_NUM-1:0]                           v_req_rdy;
  logic [REQ_NUM-1:0][PHY_REG_ID_WIDTH-1:0]     v_req_reg_index;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]           v_req_data;
  logic                                         cancel_en;

  logic [PORT_NUM-1:0]                          v_fwd_en;
  logic [PORT_NUM-1:0][PHY_REG_ID_WIDTH-1:0]    v_fwd_reg_index;
  logic [PORT_NUM-1:0][EU_NUM_WIDTH-1:0]        v_fwd_src_id;

  logic [PORT_NUM-1:0]                          v_port_en;
  logic [PORT_NUM-1:0][PHY_REG_ID_WIDTH-1:0]    v_port_reg_index;
  logic [PORT_NUM-1:0][DATA_WIDTH-1:0]          v_port_data;
  logic [PORT_NUM-1:0][EU_NUM_WIDTH-1:0]        v_port_src_id;

  modport master (
    output v_req_vld, v_req_reg_index, v_req_data, cancel_en,
    input  v_req_rdy, v_fwd_en, v_fwd_reg_index, v_fwd_src_id,
    input  v_port_en, v_port_reg_index, v_port_data, v_port_src_id
  );

  modport slave (
    input  v_req_vld, v_req_reg_index, v_req_data, cancel_en,
    output v_req_rdy, v_fwd_en, v_fwd_reg_index, v_fwd_src_id,
    output v_port_en, v_port_reg_index, v_port_data, v_port_src_id
  );

endinterface

// File: rtl/toy_wb_rr_multi_sel.sv
// Combinational multi-grant round-robin selector: rotates the request
// vector to start at the pointer, peels off up to PORT_NUM lowest set bits
// in order, then maps each hit back to a requester id.
module toy_wb_rr_multi_sel
  import toy_wb_port_arbiter_pkg::*;
#(
  parameter int REQ_NUM  = EU_NUM,
  parameter int PORT_NUM = WB_PORT_NUM
) (
  input  logic [REQ_NUM-1:0]                     i_req,
  input  logic [EU_NUM_WIDTH-1:0]                i_ptr,
  output logic [PORT_NUM-1:0][REQ_NUM-1:0]       o_grant_oh,
  output logic [PORT_NUM-1:0][EU_NUM_WIDTH-1:0]  o_grant_idx,
  output logic [PORT_NUM-1:0]                    o_fwd_en,
  output logic                                   o_any,
  output logic [EU_NUM_WIDTH-1:0]                o_next_ptr
);

  // One extra bit so pointer + offset never overflows before the wrap.
  localparam int SUM_W = EU_NUM_WIDTH + 1;

  logic [2*REQ_NUM-1:0] w_req_dbl;
  logic [REQ_NUM-1:0]   w_rot;
  logic [SUM_W-1:0]     w_pos   [PORT_NUM];
  logic                 w_found [PORT_NUM];
  logic [SUM_W-1:0]     w_idx   [PORT_NUM];

  assign w_req_dbl = {i_req, i_req};

  // Rotate so that bit 0 of w_rot is the requester at the pointer.
  always_comb begin
    logic [SUM_W-1:0] src;
    src   = '0;
    w_rot = '0;
    for (int j = 0; j < REQ_NUM; j++) begin
      src      = SUM_W'(i_ptr) + SUM_W'(j);
      w_rot[j] = w_req_dbl[src];
    end
  end

  // Cascaded lowest-one searches; each port masks out the previous hit.
  always_comb begin
    logic [REQ_NUM-1:0] mask;
    mask = w_rot;
    for (int k = 0; k < PORT_NUM; k++) begin
      w_found[k] = 1'b0;
      w_pos[k]   = '0;
      for (int j = REQ_NUM - 1; j >= 0; j--) begin
        if (mask[j]) begin
          w_found[k] = 1'b1;
          w_pos[k]   = SUM_W'(j);
        end
      end
      for (int j = 0; j < REQ_NUM; j++) begin
        if (w_found[k] && (w_pos[k] == SUM_W'(j))) mask[j] = 1'b0;
      end
    end
  end

  // Un-rotate each port's hit back into requester numbering.
  generate
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
      logic [SUM_W-1:0] w_sum;
      assign w_sum           = SUM_W'(i_ptr) + w_pos[gi];
      assign w_idx[gi]       = (w_sum >= SUM_W'(REQ_NUM)) ? (w_sum - SUM_W'(REQ_NUM)) : w_sum;
      assign o_grant_idx[gi] = EU_NUM_WIDTH'(w_idx[gi]);
      assign o_fwd_en[gi]    = w_found[gi];
      assign o_grant_oh[gi]  = w_found[gi] ? (REQ_NUM'(1) << w_idx[gi]) : '0;
    end
  endgenerate

  // Next pointer is one past the last granted requester, wrapping.
  always_comb begin
    logic [SUM_W-1:0] nxt;
    nxt        = '0;
    o_any      = 1'b0;
    o_next_ptr = i_ptr;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (w_found[k]) begin
        o_any = 1'b1;
        nxt   = w_idx[k] + SUM_W'(1);
        if (nxt == SUM_W'(REQ_NUM)) nxt = '0;
        o_next_ptr = EU_NUM_WIDTH'(nxt);
      end
    end
  end

endmodule

// File: rtl/toy_wb_port_arbiter.sv
// Writeback port arbiter: grants up to PORT_NUM EU results per cycle in
// round-robin order, forwards the grants combinationally and drives the
// regfile write ports one cycle later.
module toy_wb_port_arbiter
  import toy_wb_port_arbiter_pkg::*;
#(
  parameter int REQ_NUM    = EU_NUM,
  parameter int PORT_NUM   = WB_PORT_NUM,
  parameter int DATA_WIDTH = REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  toy_wb_port_arbiter_if.slave  bus
);

  logic [EU_NUM_WIDTH-1:0]                 r_rr_ptr;
  logic [PORT_NUM-1:0][REQ_NUM-1:0]        w_grant_oh;
  logic [PORT_NUM-1:0][EU_NUM_WIDTH-1:0]   w_grant_idx;
  logic [PORT_NUM-1:0]                     w_sel_en;
  logic                                    w_any;
  logic [EU_NUM_WIDTH-1:0]                 w_next_ptr;
  logic [REQ_NUM-1:0]                      w_rdy_raw;
  logic                                    w_gate;

  logic                                    r_port_en  [PORT_NUM];
  logic [PHY_REG_ID_WIDTH-1:0]             r_port_idx [PORT_NUM];
  logic [DATA_WIDTH-1:0]                   r_port_data[PORT_NUM];
  logic [EU_NUM_WIDTH-1:0]                 r_port_src [PORT_NUM];

  toy_wb_rr_multi_sel #(
    .REQ_NUM  (REQ_NUM),
    .PORT_NUM (PORT_NUM)
  ) u_sel (
    .i_req       (bus.v_req_vld),
    .i_ptr       (r_rr_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_fwd_en    (w_sel_en),
    .o_any       (w_any),
    .o_next_ptr  (w_next_ptr)
  );

  // Grants are suppressed by a flush and while reset is held.
  assign w_gate = rst_n & ~bus.cancel_en;

  // Merge per-port one-hot grants into the per-requester ready vector.
  always_comb begin
    w_rdy_raw = '0;
    for (int k = 0; k < PORT_NUM; k++) w_rdy_raw = w_rdy_raw | w_grant_oh[k];
  end

  assign bus.v_req_rdy = w_gate ? w_rdy_raw : '0;
  assign bus.v_fwd_en  = w_gate ? w_sel_en  : '0;

  // Round-robin pointer advances past the last grant; holds on flush or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_rr_ptr <= '0;
    else if (!bus.cancel_en && w_any) r_rr_ptr <= w_next_ptr;
  end

  generate
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
      assign bus.v_fwd_reg_index[gi]  = bus.v_req_reg_index[w_grant_idx[gi]];
      assign bus.v_fwd_src_id[gi]     = w_grant_idx[gi];
      assign bus.v_port_en[gi]        = r_port_en[gi];
      assign bus.v_port_reg_index[gi] = r_port_idx[gi];
      assign bus.v_port_data[gi]      = r_port_data[gi];
      assign bus.v_port_src_id[gi]    = r_port_src[gi];

      // Write-port register: enable follows forward; payload holds when idle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_port_en[gi]   <= 1'b0;
          r_port_idx[gi]  <= '0;
          r_port_data[gi] <= '0;
          r_port_src[gi]  <= '0;
        end else begin
          r_port_en[gi] <= bus.v_fwd_en[gi];
          if (bus.v_fwd_en[gi]) begin
            r_port_idx[gi]  <= bus.v_req_reg_index[w_grant_idx[gi]];
            r_port_data[gi] <= bus.v_req_data[w_grant_idx[gi]];
            r_port_src[gi]  <= w_grant_idx[gi];
          end
        end
      end
    end
  endgenerate

`ifdef TOY_SIM
  logic        w_dup;
  logic [31:0] r_grant_cnt;

  // Two granted writebacks to one physical register in the same cycle.
  always_comb begin
    w_dup = 1'b0;
    for (int a = 0; a < PORT_NUM; a++)
      for (int b = a + 1; b < PORT_NUM; b++)
        if (bus.v_fwd_en[a] && bus.v_fwd_en[b] &&
            (bus.v_fwd_reg_index[a] == bus.v_fwd_reg_index[b])) w_dup = 1'b1;
  end

  // Running total of writebacks granted since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_grant_cnt <= '0;
    else        r_grant_cnt <= r_grant_cnt + 32'($countones(bus.v_fwd_en));
  end

  // Flag duplicate-index grants.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!w_dup) else $error("duplicate writeback register index");
  end
`endif

endmodule

// File: tb/tb_toy_wb_port_arbiter.sv
// Directed bench for the writeback port arbiter.
module tb_toy_wb_port_arbiter;
  import toy_wb_port_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  toy_wb_port_arbiter_if #(.REQ_NUM(10), .PORT_NUM(4), .DATA_WIDTH(32)) bus ();

  toy_wb_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_rdy [4];
  logic [3:0] exp_ptr [4];
  logic [9:0] seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_rdy = '{10'h00F, 10'h0F0, 10'h303, 10'h03C};
    exp_ptr = '{4'd4, 4'd8, 4'd2, 4'd6};

    rst_n         = 1'b0;
    bus.cancel_en = 1'b0;
    bus.v_req_vld = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      bus.v_req_reg_index[i] = 6'(10 + i);
      bus.v_req_data[i]      = 32'h1000 + 32'(i);
    end

    // Reset state: outputs gated and cleared.
    tick();
    check("rst_rdy",     64'(bus.v_req_rdy), 64'h0);
    check("rst_fwd_en",  64'(bus.v_fwd_en),  64'h0);
    check("rst_port_en", 64'(bus.v_port_en), 64'h0);
    check("rst_data0",   64'(bus.v_port_data[0]), 64'h0);
    check("rst_ptr",     64'(dut.r_rr_ptr),  64'h0);
    bus.v_req_vld = '0;
    rst_n = 1'b1;
    tick();

    // Light load: EU0 and EU2.
    bus.v_req_vld = 10'b00_0000_0101;
    #1;
    check("light_rdy",    64'(bus.v_req_rdy),       64'h005);
    check("light_fwd_en", 64'(bus.v_fwd_en),        64'h3);
    check("light_src0",   64'(bus.v_fwd_src_id[0]), 64'd0);
    check("light_src1",   64'(bus.v_fwd_src_id[1]), 64'd2);
    check("light_idx0",   64'(bus.v_fwd_reg_index[0]), 64'd10);
    tick();
    bus.v_req_vld = '0;
    check("light_port_en",  64'(bus.v_port_en),        64'h3);
    check("light_port_src1",64'(bus.v_port_src_id[1]), 64'd2);
    check("light_port_dat1",64'(bus.v_port_data[1]),   64'h1002);
    check("light_ptr",      64'(dut.r_rr_ptr),         64'd3);

    // Data path: EU5 writes reg 37 with 0xDEADBEEF.
    bus.v_req_reg_index[5] = 6'd37;
    bus.v_req_data[5]      = 32'hDEAD_BEEF;
    bus.v_req_vld          = 10'h020;
    #1;
    check("dp_fwd_idx", 64'(bus.v_fwd_reg_index[0]), 64'd37);
    check("dp_fwd_src", 64'(bus.v_fwd_src_id[0]),    64'd5);
    check("dp_fwd_en",  64'(bus.v_fwd_en),           64'h1);
    tick();
    bus.v_req_vld = '0;
    check("dp_port_data", 64'(bus.v_port_data[0]),      64'hDEAD_BEEF);
    check("dp_port_idx",  64'(bus.v_port_reg_index[0]), 64'd37);
    check("dp_port_src",  64'(bus.v_port_src_id[0]),    64'd5);
    check("dp_ptr",       64'(dut.r_rr_ptr),            64'd6);
    tick();
    check("dp_idle_en",   64'(bus.v_port_en),           64'h0);
    check("dp_hold_data", 64'(bus.v_port_data[0]),      64'hDEAD_BEEF);

    // Move pointer to 8 via EU7.
    bus.v_req_vld = 10'h080;
    tick();
    bus.v_req_vld = '0;
    check("pre_wrap_ptr", 64'(dut.r_rr_ptr), 64'd8);

    // Wrap-around: EU9 and EU1 from pointer 8.
    bus.v_req_vld = 10'h202;
    #1;
    check("wrap_rdy",  64'(bus.v_req_rdy),       64'h202);
    check("wrap_src0", 64'(bus.v_fwd_src_id[0]), 64'd9);
    check("wrap_src1", 64'(bus.v_fwd_src_id[1]), 64'd1);
    tick();
    bus.v_req_vld = '0;
    check("wrap_ptr", 64'(dut.r_rr_ptr), 64'd2);

    // Cancel with four requests pending.
    bus.v_req_vld = 10'h03C;
    bus.cancel_en = 1'b1;
    #1;
    check("cancel_rdy",    64'(bus.v_req_rdy), 64'h0);
    check("cancel_fwd_en", 64'(bus.v_fwd_en),  64'h0);
    tick();
    check("cancel_port_en", 64'(bus.v_port_en), 64'h0);
    check("cancel_ptr",     64'(dut.r_rr_ptr),  64'd2);
    bus.cancel_en = 1'b0;
    #1;
    check("uncancel_rdy",  64'(bus.v_req_rdy),       64'h03C);
    check("uncancel_src0", 64'(bus.v_fwd_src_id[0]), 64'd2);
    tick();
    check("uncancel_port_en", 64'(bus.v_port_en), 64'hF);
    check("uncancel_ptr",     64'(dut.r_rr_ptr),  64'd6);

    // Burst from pointer 6, then reset mid-cycle.
    bus.v_req_vld = 10'h3FF;
    #1;
    check("burst_rdy0", 64'(bus.v_req_rdy), 64'h3C0);
    tick();
    check("burst_ptr0", 64'(dut.r_rr_ptr), 64'd0);
    #1;
    check("burst_rdy1", 64'(bus.v_req_rdy), 64'h00F);
    tick();
    check("burst_src3",  64'(bus.v_port_src_id[3]), 64'd3);
    check("burst_ptr1",  64'(dut.r_rr_ptr),         64'd4);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_port_en", 64'(bus.v_port_en),        64'h0);
    check("arst_src3",    64'(bus.v_port_src_id[3]), 64'h0);
    check("arst_data3",   64'(bus.v_port_data[3]),   64'h0);
    check("arst_ptr",     64'(dut.r_rr_ptr),         64'h0);
    check("arst_rdy",     64'(bus.v_req_rdy),        64'h0);
    tick();
    rst_n = 1'b1;

    // Full contention from pointer 0.
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("full_rdy%0d", c), 64'(bus.v_req_rdy), 64'(exp_rdy[c]));
      if (c < 3) seen = seen | bus.v_req_rdy;
      tick();
      check($sformatf("full_ptr%0d", c), 64'(dut.r_rr_ptr), 64'(exp_ptr[c]));
    end
    check("full_all_within_3", 64'(seen), 64'h3FF);
    bus.v_req_vld = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
